// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants for the VGA sync pipeline.
package vga_timing_pkg;

  // Horizontal timing, in pixel clocks from the start of a line
  localparam int H_VIS        = 640;
  localparam int H_SYNC_BEGIN = 656;
  localparam int H_SYNC_END   = 752;
  localparam int H_TOTAL      = 800;

  // Vertical timing, in lines from the start of a frame
  localparam int V_VIS        = 480;
  localparam int V_SYNC_BEGIN = 490;
  localparam int V_SYNC_END   = 492;
  localparam int V_TOTAL      = 525;

  // Width of the line counter and pixel coordinates
  localparam int COORD_W = 10;

  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_sync_gen_vcount.sv
// vga_vcount: vertical line counter advanced by the end-of-line strobe.
// Emits the wrapped next-line number and the decodes the top registers on
// the line boundary (visible, vsync) and at prefetch start (fetch line).
module vga_vcount
  import vga_timing_pkg::*;
#(
  parameter int V_TOTAL      = vga_timing_pkg::V_TOTAL,
  parameter int V_VIS        = vga_timing_pkg::V_VIS,
  parameter int V_SYNC_BEGIN = vga_timing_pkg::V_SYNC_BEGIN,
  parameter int V_SYNC_END   = vga_timing_pkg::V_SYNC_END
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hCountEnd,
  output logic [COORD_W-1:0] vcount,
  output logic [COORD_W-1:0] lineNext,
  output logic               nextVis,
  output logic               nextVsyncN,
  output logic               fetchLine
);

  // Next line number; any out-of-range value also folds back to line 0
  always_comb begin
    lineNext = vcount + coord_t'(1);
    if (vcount >= coord_t'(V_TOTAL - 1)) begin
      lineNext = '0;
    end
  end

  // Line-based decodes: visibility and vsync of the line about to start,
  // and whether the line after the current one will be displayed
  always_comb begin
    nextVis    = (lineNext < coord_t'(V_VIS));
    nextVsyncN = !((lineNext >= coord_t'(V_SYNC_BEGIN)) &&
                   (lineNext <  coord_t'(V_SYNC_END)));
    fetchLine  = (vcount == coord_t'(V_TOTAL - 1)) ||
                 (vcount <  coord_t'(V_VIS - 1));
  end

  // Line counter steps once per line, on the last clock of the line
  always_ff @(posedge clk) begin
    if (rst) begin
      vcount <= '0;
    end else if (hCountEnd) begin
      vcount <= lineNext;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: turns horizontal position strobes into registered
// HSYNC/VSYNC, display enable, prefetch window and frame-start pulse.
// Every output updates on the clock after its causing strobe, so it lines
// up with hcount == strobe position + 1.
// Optional build macro VGA_PIXEL_COORD_EN adds pixX/pixY coordinate outputs.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int V_TOTAL      = vga_timing_pkg::V_TOTAL,
  parameter int V_VIS        = vga_timing_pkg::V_VIS,
  parameter int V_SYNC_BEGIN = vga_timing_pkg::V_SYNC_BEGIN,
  parameter int V_SYNC_END   = vga_timing_pkg::V_SYNC_END
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hCountEnd,
  input  logic               hBeginPulse,
  input  logic               hEndPulse,
  input  logic               hVisEnd,
  input  logic               hBeginActive,
  input  logic               hEndActive,
  output logic               hsync_n,
  output logic               vsync_n,
  output logic [COORD_W-1:0] vcount,
  output logic               displayEn,
  output logic               fetchEn,
  output logic               frameStart
`ifdef VGA_PIXEL_COORD_EN
  ,
  output logic [COORD_W-1:0] pixX,
  output logic [COORD_W-1:0] pixY
`endif
);

  logic [COORD_W-1:0] lineNext;
  logic               nextVis;
  logic               nextVsyncN;
  logic               fetchLine;

  logic hVis;
  logic hAct;
  logic vVis;
  logic vFetch;

  logic hsyncNNext;
  logic vsyncNNext;
  logic hVisNext;
  logic hActNext;
  logic vVisNext;
  logic vFetchNext;
  logic displayEnNext;
  logic fetchEnNext;
  logic frameStartNext;

  vga_vcount #(
    .V_TOTAL      (V_TOTAL),
    .V_VIS        (V_VIS),
    .V_SYNC_BEGIN (V_SYNC_BEGIN),
    .V_SYNC_END   (V_SYNC_END)
  ) u_vcount (
    .clk        (clk),
    .rst        (rst),
    .hCountEnd  (hCountEnd),
    .vcount     (vcount),
    .lineNext   (lineNext),
    .nextVis    (nextVis),
    .nextVsyncN (nextVsyncN),
    .fetchLine  (fetchLine)
  );

  // Strobe-to-level next state; when set and clear strobes coincide the
  // clearing strobe wins so the level ends up deasserted
  always_comb begin
    hsyncNNext = hsync_n;
    if (hEndPulse) begin
      hsyncNNext = 1'b1;
    end else if (hBeginPulse) begin
      hsyncNNext = 1'b0;
    end

    hVisNext = hVis;
    if (hVisEnd) begin
      hVisNext = 1'b0;
    end else if (hCountEnd) begin
      hVisNext = 1'b1;
    end

    hActNext = hAct;
    if (hEndActive) begin
      hActNext = 1'b0;
    end else if (hBeginActive) begin
      hActNext = 1'b1;
    end

    vVisNext       = hCountEnd    ? nextVis    : vVis;
    vsyncNNext     = hCountEnd    ? nextVsyncN : vsync_n;
    vFetchNext     = hBeginActive ? fetchLine  : vFetch;
    displayEnNext  = hVisNext & vVisNext;
    fetchEnNext    = hActNext & vFetchNext;
    frameStartNext = hCountEnd && (lineNext == '0);
  end

  // Output and level registers; reset reproduces the hcount==0, line 0 state
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_n    <= 1'b1;
      vsync_n    <= 1'b1;
      hVis       <= 1'b1;
      hAct       <= 1'b1;
      vVis       <= 1'b1;
      vFetch     <= 1'b1;
      displayEn  <= 1'b1;
      fetchEn    <= 1'b1;
      frameStart <= 1'b0;
    end else begin
      hsync_n    <= hsyncNNext;
      vsync_n    <= vsyncNNext;
      hVis       <= hVisNext;
      hAct       <= hActNext;
      vVis       <= vVisNext;
      vFetch     <= vFetchNext;
      displayEn  <= displayEnNext;
      fetchEn    <= fetchEnNext;
      frameStart <= frameStartNext;
    end
  end

`ifdef VGA_PIXEL_COORD_EN
  logic [COORD_W-1:0] pixXNext;
  logic [COORD_W-1:0] pixYNext;
  logic [COORD_W-1:0] lineCur;

  // Coordinates follow the same next-state as displayEn so they stay aligned
  always_comb begin
    lineCur  = hCountEnd ? lineNext : vcount;
    pixXNext = '0;
    if (displayEnNext && displayEn) begin
      pixXNext = pixX + coord_t'(1);
    end
    pixYNext = vVisNext ? lineCur : '0;
  end

  // Coordinate registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pixX <= '0;
      pixY <= '0;
    end else begin
      pixX <= pixXNext;
      pixY <= pixYNext;
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: an hcount/line position model drives the strobes,
// and every cycle's outputs are compared with values derived directly from
// the position (plus per-frame totals). Vertical timing is shrunk so that
// whole frames fit in a short run; horizontal timing is the real 800 clk.
module tb_vga_sync_gen;

  localparam int H_T  = 800;
  localparam int V_T  = 16;
  localparam int V_V  = 10;
  localparam int V_SB = 12;
  localparam int V_SE = 14;
  localparam int FRAME = H_T * V_T;

  logic       clk;
  logic       rst;
  logic       hCountEnd;
  logic       hBeginPulse;
  logic       hEndPulse;
  logic       hVisEnd;
  logic       hBeginActive;
  logic       hEndActive;
  logic       hsync_n;
  logic       vsync_n;
  logic [9:0] vcount;
  logic       displayEn;
  logic       fetchEn;
  logic       frameStart;
`ifdef VGA_PIXEL_COORD_EN
  logic [9:0] pixX;
  logic [9:0] pixY;
`endif

  int checkCount;
  int errorCount;
  int hc;
  int vc;
  bit wrapped;
  bit frameFromReset;
  int dispCnt;
  int fetchCnt;
  int vsLowCnt;
  int fsCnt;
  int framesChecked;

  vga_sync_gen #(
    .V_TOTAL      (V_T),
    .V_VIS        (V_V),
    .V_SYNC_BEGIN (V_SB),
    .V_SYNC_END   (V_SE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .hCountEnd    (hCountEnd),
    .hBeginPulse  (hBeginPulse),
    .hEndPulse    (hEndPulse),
    .hVisEnd      (hVisEnd),
    .hBeginActive (hBeginActive),
    .hEndActive   (hEndActive),
    .hsync_n      (hsync_n),
    .vsync_n      (vsync_n),
    .vcount       (vcount),
    .displayEn    (displayEn),
    .fetchEn      (fetchEn),
    .frameStart   (frameStart)
`ifdef VGA_PIXEL_COORD_EN
    ,
    .pixX         (pixX),
    .pixY         (pixY)
`endif
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("FAIL %s observed=%0d expected=%0d (line %0d h %0d)", tag, obs, exp, vc, hc);
    end
  endtask

  function automatic bit visible(input int h, input int v);
    return (h < 640) && (v < V_V);
  endfunction

  task automatic driveStrobes(input int h);
    hCountEnd    = (h == 799);
    hBeginPulse  = (h == 655);
    hEndPulse    = (h == 751);
    hVisEnd      = (h == 639);
    hBeginActive = (h == 793);
    hEndActive   = (h == 633);
  endtask

  task automatic clearCounters();
    dispCnt  = 0;
    fetchCnt = 0;
    vsLowCnt = 0;
    fsCnt    = 0;
  endtask

  // Totals over one complete frame that started at line 0, hcount 0
  task automatic frameCheck();
    chk("frame_display_count", 32'(dispCnt), 32'(V_V * 640));
    chk("frame_fetch_count", 32'(fetchCnt), 32'(V_V * 640));
    chk("frame_vsync_low_clk", 32'(vsLowCnt), 32'((V_SE - V_SB) * H_T));
    chk("frame_start_count", 32'(fsCnt), frameFromReset ? 32'd0 : 32'd1);
    framesChecked++;
    clearCounters();
  endtask

  // Expected outputs at the current position, straight from the timing rules
  task automatic checkCycle();
    int  h2;
    int  v2;
    bit  expFetch;
    h2 = hc + 6;
    v2 = vc;
    if (h2 >= H_T) begin
      h2 = h2 - H_T;
      v2 = (vc + 1) % V_T;
    end
    expFetch = visible(h2, v2);
    chk("hsync_n", 32'(hsync_n), 32'(!((hc >= 656) && (hc < 752))));
    chk("vsync_n", 32'(vsync_n), 32'(!((vc >= V_SB) && (vc < V_SE))));
    chk("vcount", 32'(vcount), 32'(vc));
    chk("displayEn", 32'(displayEn), 32'(visible(hc, vc)));
    chk("fetchEn", 32'(fetchEn), 32'(expFetch));
    chk("frameStart", 32'(frameStart), 32'((hc == 0) && (vc == 0) && wrapped));
`ifdef VGA_PIXEL_COORD_EN
    chk("pixX", 32'(pixX), visible(hc, vc) ? 32'(hc) : 32'd0);
    chk("pixY", 32'(pixY), (vc < V_V) ? 32'(vc) : 32'd0);
`endif
    dispCnt  += int'(displayEn);
    fetchCnt += int'(fetchEn);
    vsLowCnt += int'(!vsync_n);
    fsCnt    += int'(frameStart);
  endtask

  // One clock: optional reset (with random strobe noise that reset must
  // override), advance the position model, drive strobes, check outputs
  task automatic step(input bit doRst);
    rst = doRst;
    if (doRst) begin
      {hCountEnd, hBeginPulse, hEndPulse, hVisEnd, hBeginActive, hEndActive} = 6'($urandom);
    end
    @(posedge clk);
    #1;
    if (doRst) begin
      hc = 0;
      vc = 0;
      wrapped = 1'b0;
      frameFromReset = 1'b1;
      clearCounters();
    end else begin
      hc++;
      if (hc == H_T) begin
        hc = 0;
        vc = (vc + 1) % V_T;
        if (vc == 0) begin
          frameCheck();
          wrapped = 1'b1;
          frameFromReset = 1'b0;
        end
      end
    end
    driveStrobes(hc);
    @(negedge clk);
    checkCycle();
  endtask

  initial begin
    int rl;
    int rh;
    int hold;
    int extra;
    checkCount = 0;
    errorCount = 0;
    framesChecked = 0;
    hc = 0;
    vc = 0;
    wrapped = 1'b0;
    frameFromReset = 1'b1;
    clearCounters();
    rst = 1'b1;
    driveStrobes(0);
    @(negedge clk);

    // Reset for three clocks, then two full frames
    for (int i = 0; i < 3; i++) step(1'b1);
    for (int i = 0; i < 2 * FRAME; i++) step(1'b0);

    // Reset at a random mid-frame position, hold a random number of clocks
    rl = $urandom_range(V_T - 1, 1);
    rh = $urandom_range(H_T - 1, 0);
    for (int i = 0; i < FRAME && !((vc == rl) && (hc == rh)); i++) step(1'b0);
    chk("reached_reset_point", 32'((vc == rl) && (hc == rh)), 32'd1);
    hold = $urandom_range(3, 1);
    for (int i = 0; i < hold; i++) step(1'b1);

    // One more full frame plus a random partial line
    extra = $urandom_range(H_T - 1, 0);
    for (int i = 0; i < FRAME + extra; i++) step(1'b0);

    chk("frames_checked", 32'(framesChecked), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
